// File: rtl/scmp_pkg.sv
// Shared encodings for the scmp core: opcode/funct constants, ALU operation enum,
// the decoded control bundle, and the 16-bit immediate sign-extension helper.
package scmp_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_SLTI  = 6'h0A;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {ADD, SUB, AND, OR, NOR, SLT} alu_op_e;

   typedef struct packed {
      logic    reg_we;
      logic    dst_rd;
      logic    src_imm;
      logic    imm_zext;
      logic    mem_we;
      logic    mem_rd;
      logic    branch;
      logic    jump;
      alu_op_e alu_op;
   } ctrl_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/scmp_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 hardwired to zero.
// Reads return pre-edge contents; a write lands at the clock edge and a synchronous reset clears every register.
module scmp_regfile
   import scmp_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr1_i,
   output logic [31:0] rdata1_o,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata2_o
);

   logic [31:0] regmem [0:31];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            regmem[i] <= '0;
         end
      end else if (we_i && (waddr_i != 5'd0)) begin
         regmem[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = regmem[raddr1_i];
   assign rdata2_o = regmem[raddr2_i];

endmodule

// File: rtl/scmp.sv
// scmp: single-cycle MIPS-subset core; fetch/decode/execute/writeback all complete in one clk, no stalls.
// `SCMP_IMM_LOGIC_EN adds andi/ori/slti. Memory images are placed into imem/dmem by the simulation environment (depths are powers of two).
module scmp
   import scmp_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256,
   parameter     IMEM_INIT  = "imem.hex",
   parameter     DMEM_INIT  = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] next_add
);

   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   // Image names are consumed by the preload step, not by the datapath.
   localparam int unused_init_bits = $bits(IMEM_INIT) + $bits(DMEM_INIT);

   logic [31:0] imem [0:IMEM_DEPTH-1];
   logic [31:0] dmem [0:DMEM_DEPTH-1];

   logic [31:0] pc_q, pc_d, pc_plus1;
   logic [31:0] instr;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, waddr;
   logic [15:0] imm;
   logic [25:0] target;
   ctrl_t       ctrl;
   logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_res, wb_dat;
   logic [DAW-1:0] dmem_idx;

   assign instr  = imem[pc_q[IAW-1:0]];
   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];
   assign target = instr[25:0];

   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ADD;
      case (opcode)
         OP_RTYPE: begin
            ctrl.dst_rd = 1'b1;
            ctrl.reg_we = 1'b1;
            case (funct)
               FN_ADD:  ctrl.alu_op = ADD;
               FN_SUB:  ctrl.alu_op = SUB;
               FN_AND:  ctrl.alu_op = AND;
               FN_OR:   ctrl.alu_op = OR;
               FN_NOR:  ctrl.alu_op = NOR;
               FN_SLT:  ctrl.alu_op = SLT;
               default: ctrl.reg_we = 1'b0;
            endcase
         end
         OP_ADDI: begin
            ctrl.reg_we  = 1'b1;
            ctrl.src_imm = 1'b1;
         end
         OP_LW: begin
            ctrl.reg_we  = 1'b1;
            ctrl.src_imm = 1'b1;
            ctrl.mem_rd  = 1'b1;
         end
         OP_SW: begin
            ctrl.mem_we  = 1'b1;
            ctrl.src_imm = 1'b1;
         end
         OP_BEQ:  ctrl.branch = 1'b1;
         OP_J:    ctrl.jump   = 1'b1;
`ifdef SCMP_IMM_LOGIC_EN
         OP_ANDI: begin
            ctrl.reg_we   = 1'b1;
            ctrl.src_imm  = 1'b1;
            ctrl.imm_zext = 1'b1;
            ctrl.alu_op   = AND;
         end
         OP_ORI: begin
            ctrl.reg_we   = 1'b1;
            ctrl.src_imm  = 1'b1;
            ctrl.imm_zext = 1'b1;
            ctrl.alu_op   = OR;
         end
         OP_SLTI: begin
            ctrl.reg_we  = 1'b1;
            ctrl.src_imm = 1'b1;
            ctrl.alu_op  = SLT;
         end
`endif
         default: ;
      endcase
   end

   scmp_regfile Reg1 (
      .clk_i    (clk),
      .rst_i    (rst),
      .we_i     (ctrl.reg_we & ~rst),
      .waddr_i  (waddr),
      .wdata_i  (wb_dat),
      .raddr1_i (rs),
      .rdata1_o (rs_val),
      .raddr2_i (rt),
      .rdata2_o (rt_val)
   );

   assign imm_ext = ctrl.imm_zext ? {16'd0, imm} : sign_ext16(imm);
   assign alu_b   = ctrl.src_imm ? imm_ext : rt_val;

   always_comb begin
      alu_res = rs_val + alu_b;
      case (ctrl.alu_op)
         ADD:     alu_res = rs_val + alu_b;
         SUB:     alu_res = rs_val - alu_b;
         AND:     alu_res = rs_val & alu_b;
         OR:      alu_res = rs_val | alu_b;
         NOR:     alu_res = ~(rs_val | alu_b);
         SLT:     alu_res = {31'd0, $signed(rs_val) < $signed(alu_b)};
         default: ;
      endcase
   end

   // Byte address from the ALU; the two low bits are dropped to form the word index.
   assign dmem_idx = alu_res[DAW+1:2];
   assign wb_dat   = ctrl.mem_rd ? dmem[dmem_idx] : alu_res;
   assign waddr    = ctrl.dst_rd ? rd : rt;

   always_ff @(posedge clk) begin
      if (!rst && ctrl.mem_we) begin
         dmem[dmem_idx] <= rt_val;
      end
   end

   assign pc_plus1 = pc_q + 32'd1;

   always_comb begin
      pc_d = pc_plus1;
      if (ctrl.jump) begin
         pc_d = {pc_q[31:26], target};
      end else if (ctrl.branch && (rs_val == rt_val)) begin
         pc_d = pc_plus1 + sign_ext16(imm);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= next_add;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: tb/tb_scmp.sv
// Directed and random program runs on scmp, checked each cycle against an instruction-level model.
module tb_scmp;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] next_add;

   scmp dut (
      .clk      (clk),
      .rst      (rst),
      .next_add (next_add)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] prog   [256];
   logic [31:0] m_reg  [32];
   logic [31:0] m_dmem [256];
   logic [31:0] m_pc;

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(int tgt);
      return {6'h02, 26'(tgt)};
   endfunction

   task automatic load(input logic [7:0] a, input logic [31:0] w);
      prog[a]     = w;
      dut.imem[a] = w;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int r, input logic [31:0] v);
      if (r != 0) m_reg[r] = v;
   endtask

   task automatic model_reset();
      m_pc = next_add;
      for (int r = 0; r < 32; r++) m_reg[r] = '0;
   endtask

   // Instruction-set interpreter: one architectural instruction per call.
   task automatic model_step();
      logic [31:0] ins, a, b, sx, zx, addr, nxt;
      int rs, rt, rd;
      ins  = prog[m_pc % 256];
      rs   = int'(ins[25:21]);
      rt   = int'(ins[20:16]);
      rd   = int'(ins[15:11]);
      a    = m_reg[rs];
      b    = m_reg[rt];
      sx   = {{16{ins[15]}}, ins[15:0]};
      zx   = {16'd0, ins[15:0]};
      addr = a + sx;
      nxt  = m_pc + 1;
      case (ins[31:26])
         6'h00: case (ins[5:0])
            6'h20: wr(rd, a + b);
            6'h22: wr(rd, a - b);
            6'h24: wr(rd, a & b);
            6'h25: wr(rd, a | b);
            6'h27: wr(rd, ~(a | b));
            6'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            default: ;
         endcase
         6'h08: wr(rt, a + sx);
         6'h23: wr(rt, m_dmem[(addr >> 2) % 256]);
         6'h2B: m_dmem[(addr >> 2) % 256] = b;
         6'h04: if (a == b) nxt = m_pc + 1 + sx;
         6'h02: nxt = {m_pc[31:26], ins[25:0]};
`ifdef SCMP_IMM_LOGIC_EN
         6'h0C: wr(rt, a & zx);
         6'h0D: wr(rt, a | zx);
         6'h0A: wr(rt, ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0);
`endif
         default: ;
      endcase
      m_pc = nxt;
   endtask

   task automatic check_state();
      check("pc", dut.pc_q, m_pc);
      for (int r = 0; r < 32; r++) check($sformatf("r%0d", r), dut.Reg1.regmem[r], m_reg[r]);
   endtask

   task automatic check_dmem();
      for (int i = 0; i < 256; i++) check($sformatf("dmem%0d", i), dut.dmem[i], m_dmem[i]);
   endtask

   task automatic cycle(input logic do_rst);
      rst = do_rst;
      if (do_rst) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      check_state();
   endtask

   function automatic logic [31:0] rand_instr();
      int k, rs, rt, rd;
      logic [5:0] fns [6];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
      k  = int'($urandom_range(0, 13));
      rs = int'($urandom_range(0, 7));
      rt = int'($urandom_range(0, 7));
      rd = int'($urandom_range(0, 7));
      case (k)
         0:       return enc_i('h08, rs, rt, int'($urandom_range(0, 65535)));
         7:       return enc_i('h23, rs, rt, int'($urandom_range(0, 65535)));
         8:       return enc_i('h2B, rs, rt, int'($urandom_range(0, 65535)));
         9:       return enc_i('h04, rs, rt, int'($urandom_range(0, 2)));
         10:      return enc_i('h0C, rs, rt, int'($urandom_range(0, 65535)));
         11:      return enc_i('h0D, rs, rt, int'($urandom_range(0, 65535)));
         12:      return enc_i('h0A, rs, rt, int'($urandom_range(0, 65535)));
         13:      return ($urandom_range(0, 1) == 0) ? enc_i('h3F, rs, rt, 7) : enc_r(rs, rt, rd, 'h3F);
         default: return enc_r(rs, rt, rd, int'(fns[k-1]));
      endcase
   endfunction

   initial begin
      rst      = 1'b1;
      next_add = 32'd1;
      for (int i = 0; i < 256; i++) begin
         load(8'(i), 32'd0);
         m_dmem[i] = '0;
      end
      load(1,  32'h20060005);
      load(2,  enc_i('h08, 0, 7, 3));
      load(3,  enc_r(6, 7, 6, 'h22));
      load(4,  enc_i('h2B, 0, 6, 8));
      load(5,  enc_i('h23, 0, 8, 8));
      load(6,  enc_i('h08, 0, 0, 7));
      load(7,  enc_i('h04, 6, 8, 2));
      load(8,  enc_i('h08, 0, 9, 1));
      load(9,  enc_i('h08, 0, 9, 1));
      load(10, enc_i('h04, 6, 7, 5));
      load(11, enc_i('h08, 0, 10, -1));
      load(12, enc_i('h08, 0, 11, 1));
      load(13, enc_r(10, 11, 12, 'h2A));
      load(14, enc_i('h0D, 0, 6, 'hFFFF));
      load(15, enc_j(1));

      // reset load
      cycle(1);
      check("reset_pc", dut.pc_q, 32'd1);
      check("reset_r6", dut.Reg1.regmem[6], 32'd0);

      cycle(0); check("addi_r6", dut.Reg1.regmem[6], 32'd5);
      cycle(0); check("addi_r7", dut.Reg1.regmem[7], 32'd3);
      cycle(0); check("sub_r6", dut.Reg1.regmem[6], 32'd2);
      cycle(0); check("sw_dmem2", dut.dmem[2], 32'd2);
      cycle(0); check("lw_r8", dut.Reg1.regmem[8], 32'd2);
      cycle(0); check("r0_stays0", dut.Reg1.regmem[0], 32'd0);
      cycle(0); check("beq_taken_pc", dut.pc_q, 32'd10);
      cycle(0); check("beq_nottaken_pc", dut.pc_q, 32'd11);
      cycle(0);
      cycle(0);
      cycle(0); check("slt_neg", dut.Reg1.regmem[12], 32'd1);
      cycle(0);
`ifdef SCMP_IMM_LOGIC_EN
      check("ori_r6", dut.Reg1.regmem[6], 32'h0000FFFF);
`else
      check("ori_nop_r6", dut.Reg1.regmem[6], 32'd2);
`endif
      cycle(0); check("j_pc", dut.pc_q, 32'd1);

      // mid-run reset with a store of a different value in flight
      load(4, enc_i('h2B, 0, 10, 8));
      cycle(0); cycle(0); cycle(0);
      check("pre_rst_pc", dut.pc_q, 32'd4);
      cycle(1);
      check("midrst_pc", dut.pc_q, 32'd1);
      check("midrst_r10", dut.Reg1.regmem[10], 32'd0);
      check("midrst_dmem2", dut.dmem[2], 32'd2);

      // PC wrap and jump region bits
      load(255, enc_j(1));
      next_add = 32'hFFFF_FFFF;
      cycle(1);
      cycle(0); check("j_region_pc", dut.pc_q, 32'hFC00_0001);
      cycle(0);
      load(255, enc_i('h08, 0, 5, 9));
      cycle(1);
      cycle(0);
      check("wrap_pc", dut.pc_q, 32'd0);
      check("wrap_r5", dut.Reg1.regmem[5], 32'd9);

      // clear data memory with a small loop, then run random code
      load(200, enc_i('h08, 0, 1, 0));
      load(201, enc_i('h08, 0, 2, 256));
      load(202, enc_i('h2B, 1, 0, 0));
      load(203, enc_i('h08, 1, 1, 4));
      load(204, enc_i('h08, 2, 2, -1));
      load(205, enc_i('h04, 2, 0, 1));
      load(206, enc_j(202));
      for (int i = 207; i <= 247; i++) load(8'(i), rand_instr());
      for (int i = 248; i <= 250; i++) load(8'(i), enc_j(207));
      next_add = 32'd200;
      cycle(1);
      for (int n = 0; n < 2000 && m_pc != 32'd207; n++) cycle(0);
      check("clear_loop_exit", dut.pc_q, 32'd207);
      check_dmem();

      for (int n = 0; n < 600; n++) cycle(0);
      check_dmem();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
